// File: rtl/keypad_entry_ctrl_pkg.sv
// Shared types, scan-code constants, segment patterns and the key decoder
// for the keypad entry controller and its display decoder.
package keypad_pkg;

  typedef enum logic [1:0] {IDLE, ENTRY, FULL, DONE} state_e;

  typedef enum logic [1:0] {KEY_DIGIT, KEY_STAR, KEY_HASH, KEY_NONE} key_class_e;

  typedef struct packed {
    key_class_e kclass;
    logic [3:0] digit;
  } key_t;

  localparam logic [3:0] CODE_STAR = 4'd12;
  localparam logic [3:0] CODE_HASH = 4'd14;

  // Active-low {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Scanner code {row,col} to key class and BCD digit; column 3 is unpopulated.
  function automatic key_t key_decode(input logic [3:0] code);
    key_t k;
    k.kclass = KEY_DIGIT;
    k.digit  = 4'd0;
    case (code)
      4'd0:      k.digit = 4'd1;
      4'd1:      k.digit = 4'd2;
      4'd2:      k.digit = 4'd3;
      4'd4:      k.digit = 4'd4;
      4'd5:      k.digit = 4'd5;
      4'd6:      k.digit = 4'd6;
      4'd8:      k.digit = 4'd7;
      4'd9:      k.digit = 4'd8;
      4'd10:     k.digit = 4'd9;
      4'd13:     k.digit = 4'd0;
      CODE_STAR: k.kclass = KEY_STAR;
      CODE_HASH: k.kclass = KEY_HASH;
      default:   k.kclass = KEY_NONE;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/keypad_entry_ctrl_if.sv
// Key-event input and display/result output bundle of the keypad entry controller.
interface keypad_entry_ctrl_if;
  logic [3:0]  key_code;
  logic        key_valid;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic [15:0] value;
  logic        done;
  logic        err;

  modport master (
    output key_code, key_valid,
    input  an, seg, value, done, err
  );

  modport slave (
    input  key_code, key_valid,
    output an, seg, value, done, err
  );
endinterface

// File: rtl/keypad_entry_ctrl_seg7_decode.sv
// Combinational BCD to active-low 7-segment decoder; codes above 9 show blank.
module seg7_decode
  import keypad_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/keypad_entry_ctrl.sv
// Keypad numeric-entry sequencer: synchronizes scanner events, builds a BCD
// entry with clear/commit/timeout, and refreshes a 4-digit multiplexed display.
module keypad_entry_ctrl
  import keypad_pkg::*;
#(
  parameter int unsigned DIGITS        = 4,
  parameter int unsigned SCAN_DIV      = 4096,
  parameter int unsigned TIMEOUT_TICKS = 2000
) (
  input logic               clk4m,
  input logic               rst,
  keypad_entry_ctrl_if.slave bus
);

  localparam int unsigned SCAN_W = $clog2(SCAN_DIV);
  localparam int unsigned REF_W  = SCAN_W + 2;
  localparam int unsigned TO_W   = $clog2(TIMEOUT_TICKS + 1);
  localparam int unsigned CNT_W  = $clog2(DIGITS + 1);
  localparam int unsigned BUF_W  = 4 * DIGITS;

  logic [2:0] vsync;
  logic [3:0] csync1, csync2;
  logic       key_stb;

  // Synchronizer resets high so a key_valid level already present at reset
  // release is not mistaken for a fresh rising edge.
  always_ff @(posedge clk4m) begin
    if (rst) begin
      vsync  <= '1;
      csync1 <= '0;
      csync2 <= '0;
    end else begin
      vsync  <= {vsync[1:0], bus.key_valid};
      csync1 <= bus.key_code;
      csync2 <= csync1;
    end
  end

  assign key_stb = vsync[1] & ~vsync[2];

  logic [REF_W-1:0] refresh;
  logic             tick;
  logic [1:0]       pos;

  always_ff @(posedge clk4m) begin
    if (rst) refresh <= '0;
    else     refresh <= refresh + 1'b1;
  end

  assign tick = &refresh[SCAN_W-1:0];
  assign pos  = refresh[REF_W-1 -: 2];

  state_e           state, state_nxt;
  logic [BUF_W-1:0] entry_buf, buf_nxt;
  logic [CNT_W-1:0] count, count_nxt;
  logic [BUF_W-1:0] value_q, value_nxt;
  logic [TO_W-1:0]  tcnt, tcnt_nxt;
  logic             done_q, done_nxt;
  logic             err_q, err_nxt;
  key_t             key;

  always_ff @(posedge clk4m) begin
    if (rst) begin
      state     <= IDLE;
      entry_buf <= '0;
      count     <= '0;
      value_q   <= '0;
      tcnt      <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state     <= state_nxt;
      entry_buf <= buf_nxt;
      count     <= count_nxt;
      value_q   <= value_nxt;
      tcnt      <= tcnt_nxt;
      done_q    <= done_nxt;
      err_q     <= err_nxt;
    end
  end

  always_comb begin
    key       = key_decode(csync2);
    state_nxt = state;
    buf_nxt   = entry_buf;
    count_nxt = count;
    value_nxt = value_q;
    tcnt_nxt  = tcnt;
    done_nxt  = 1'b0;
    err_nxt   = 1'b0;

    if (key_stb) begin
      // Any key restarts the inactivity timer, even if it also coincides with a tick.
      tcnt_nxt = '0;
      unique case (key.kclass)
        KEY_DIGIT: begin
          unique case (state)
            IDLE, DONE: begin
              buf_nxt   = {{(BUF_W-4){1'b0}}, key.digit};
              count_nxt = CNT_W'(1);
              state_nxt = ENTRY;
            end
            ENTRY: begin
              buf_nxt   = {entry_buf[BUF_W-5:0], key.digit};
              count_nxt = count + 1'b1;
              if (count == CNT_W'(DIGITS - 1)) state_nxt = FULL;
            end
            FULL: err_nxt = 1'b1;
          endcase
        end
        KEY_HASH: begin
          if (state == ENTRY || state == FULL) begin
            value_nxt = entry_buf;
            done_nxt  = 1'b1;
            state_nxt = DONE;
          end else begin
            err_nxt = 1'b1;
          end
        end
        KEY_STAR: begin
          buf_nxt   = '0;
          count_nxt = '0;
          state_nxt = IDLE;
        end
        KEY_NONE: ;
      endcase
    end else if (tick && (state == ENTRY || state == FULL)) begin
      if (tcnt == TO_W'(TIMEOUT_TICKS - 1)) begin
        buf_nxt   = '0;
        count_nxt = '0;
        tcnt_nxt  = '0;
        state_nxt = IDLE;
      end else begin
        tcnt_nxt = tcnt + 1'b1;
      end
    end

    if (state == IDLE || state == DONE) tcnt_nxt = '0;
  end

  logic [3:0] nib;
  logic [6:0] seg_c;
  logic [3:0] an_q;
  logic [6:0] seg_q;

  // Blank positions are forced to an out-of-range code, which the decoder blanks.
  always_comb begin
    nib = 4'hF;
    unique case (state)
      DONE: nib = value_q[{pos, 2'b00} +: 4];
      ENTRY, FULL: begin
        if (CNT_W'(pos) < count) nib = entry_buf[{pos, 2'b00} +: 4];
      end
      IDLE: nib = 4'hF;
    endcase
  end

  seg7_decode u_seg7_decode (
    .bcd (nib),
    .seg (seg_c)
  );

  always_ff @(posedge clk4m) begin
    if (rst) begin
      an_q  <= '1;
      seg_q <= SEG_BLANK;
    end else begin
      an_q  <= ~(4'b0001 << pos);
      seg_q <= seg_c;
    end
  end

  assign bus.an    = an_q;
  assign bus.seg   = seg_q;
  assign bus.value = value_q;
  assign bus.done  = done_q;
  assign bus.err   = err_q;

endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// Bench for keypad_entry_ctrl: directed keypad scenarios plus random key traffic,
// checked every cycle against a digit-queue reference model of the keypad entry.
module tb_keypad_entry_ctrl;

  localparam int unsigned SD = 16;
  localparam int unsigned TO = 8;

  logic clk4m = 1'b0;
  logic rst   = 1'b1;

  keypad_entry_ctrl_if kif ();

  keypad_entry_ctrl #(
    .DIGITS        (4),
    .SCAN_DIV      (SD),
    .TIMEOUT_TICKS (TO)
  ) dut (
    .clk4m (clk4m),
    .rst   (rst),
    .bus   (kif.slave)
  );

  always #5 clk4m = ~clk4m;

  int checks   = 0;
  int failures = 0;
  int m_k      = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, m_k);
    end
  endtask

  // Reference model: keypad layout string, lit-segment table, digit queue.
  string      KP = "123x456x789x*0#x";
  logic [6:0] SEG_ON [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                              7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  bit          h1, h2, h3;
  logic [3:0]  c1, c2;
  int          ent[$];
  bit          active, committed;
  int          idle_ticks;
  logic [15:0] m_value;
  logic [3:0]  m_an;
  logic [6:0]  m_seg;
  bit          m_done, m_err;
  bit          chk_en = 1'b0;
  int          mp, md;
  bit          stb;
  byte         ch;

  always @(posedge clk4m) begin
    if (rst) begin
      chk_en = 1'b1;
      m_k = 0;
      h1 = 1; h2 = 1; h3 = 1;
      c1 = '0; c2 = '0;
      ent.delete();
      active = 0; committed = 0; idle_ticks = 0;
      m_value = '0;
      m_an = 4'hF; m_seg = 7'h7F; m_done = 0; m_err = 0;
    end else begin
      m_k++;
      mp = ((m_k - 1) / SD) % 4;
      m_an = ~(4'b0001 << mp);
      m_seg = 7'h7F;
      if (committed) m_seg = ~SEG_ON[m_value[mp*4 +: 4]];
      else if (active && mp < ent.size()) m_seg = ~SEG_ON[ent[ent.size()-1-mp]];

      stb = h2 && !h3;
      ch  = KP[c2];
      h3 = h2; h2 = h1; h1 = kif.key_valid;
      c2 = c1; c1 = kif.key_code;
      m_done = 0; m_err = 0;

      if (stb) begin
        if (ch >= "0" && ch <= "9") begin
          md = ch - "0";
          if (!active) begin
            ent.delete(); ent.push_back(md);
            active = 1; committed = 0;
          end else if (ent.size() == 4) m_err = 1;
          else ent.push_back(md);
        end else if (ch == "#") begin
          if (active) begin
            m_value = '0;
            foreach (ent[i]) m_value = {m_value[11:0], 4'(ent[i])};
            m_done = 1; committed = 1; active = 0;
            ent.delete();
          end else m_err = 1;
        end else if (ch == "*") begin
          ent.delete(); active = 0; committed = 0;
        end
        idle_ticks = 0;
      end else if (active && (m_k % SD) == 0) begin
        if (idle_ticks == TO - 1) begin
          ent.delete(); active = 0; idle_ticks = 0;
        end else idle_ticks++;
      end
    end
  end

  int done_seen = 0;
  int err_seen  = 0;

  always @(negedge clk4m) begin
    if (chk_en) begin
      check_eq("an",    kif.an,    m_an);
      check_eq("seg",   kif.seg,   m_seg);
      check_eq("value", kif.value, m_value);
      check_eq("done",  kif.done,  m_done);
      check_eq("err",   kif.err,   m_err);
      if (kif.done) done_seen++;
      if (kif.err)  err_seen++;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk4m);
  endtask

  task automatic press(input logic [3:0] code, input int hold, input int gap);
    @(negedge clk4m);
    kif.key_code  = code;
    kif.key_valid = 1'b1;
    cyc(hold);
    kif.key_valid = 1'b0;
    cyc(gap);
  endtask

  task automatic hash_latency();
    @(negedge clk4m);
    kif.key_code  = 4'd14;
    kif.key_valid = 1'b1;
    cyc(2);
    check_eq("done_before_3", kif.done, 1'b0);
    cyc(1);
    check_eq("done_at_3", kif.done, 1'b1);
    cyc(1);
    check_eq("done_one_cycle", kif.done, 1'b0);
    kif.key_valid = 1'b0;
    cyc(4);
  endtask

  int e0, d0, r;

  initial begin
    kif.key_valid = 1'b0;
    kif.key_code  = 4'd0;
    rst = 1'b1;
    cyc(3);
    rst = 1'b0;
    check_eq("rst_an",    kif.an,    4'hF);
    check_eq("rst_seg",   kif.seg,   7'h7F);
    check_eq("rst_value", kif.value, 16'h0000);
    check_eq("rst_done",  kif.done,  1'b0);
    check_eq("rst_err",   kif.err,   1'b0);

    cyc(20000);
    check_eq("idle_done_cnt", done_seen, 0);
    check_eq("idle_err_cnt",  err_seen,  0);

    press(4'd0, 2, 4); press(4'd4, 2, 4); press(4'd9, 2, 4);
    hash_latency();
    check_eq("value_0148", kif.value, 16'h0148);
    cyc(4 * SD);

    e0 = err_seen;
    press(4'd13, 2, 4); press(4'd13, 2, 4); press(4'd0, 2, 4); press(4'd1, 2, 4);
    press(4'd2, 2, 4);
    check_eq("full_err_cnt", err_seen - e0, 1);
    check_eq("full_value_kept", kif.value, 16'h0148);
    press(4'd14, 2, 4);
    check_eq("value_0012", kif.value, 16'h0012);

    press(4'd5, 2, 4); press(4'd6, 2, 4); press(4'd12, 2, 4);
    check_eq("star_value_kept", kif.value, 16'h0012);
    e0 = err_seen; d0 = done_seen;
    press(4'd14, 2, 4);
    check_eq("hash_idle_err", err_seen - e0, 1);
    check_eq("hash_idle_done", done_seen - d0, 0);
    cyc(4 * SD);

    d0 = done_seen;
    press(4'd10, 2, 4);
    cyc((TO + 2) * SD);
    check_eq("timeout_done", done_seen - d0, 0);
    check_eq("timeout_blank", kif.seg, 7'h7F);
    press(4'd10, 2, 4);
    cyc((TO - 2) * SD);
    press(4'd9, 2, 4);
    cyc((TO - 2) * SD);
    press(4'd14, 2, 4);
    check_eq("survive_value", kif.value, 16'h0098);

    e0 = err_seen;
    press(4'd3, 2, 4); press(4'd7, 2, 4); press(4'd11, 2, 4); press(4'd15, 2, 4);
    check_eq("none_err", err_seen - e0, 0);
    check_eq("none_value", kif.value, 16'h0098);

    press(4'd5, 2, 4);
    @(negedge clk4m);
    kif.key_code  = 4'd6;
    kif.key_valid = 1'b1;
    rst = 1'b1;
    cyc(3);
    rst = 1'b0;
    check_eq("midrst_value", kif.value, 16'h0000);
    check_eq("midrst_an",    kif.an,    4'hF);
    e0 = err_seen; d0 = done_seen;
    cyc(10);
    kif.key_valid = 1'b0;
    cyc(4 * SD);
    check_eq("midrst_no_err",  err_seen - e0, 0);
    check_eq("midrst_no_done", done_seen - d0, 0);
    check_eq("midrst_blank",   kif.seg, 7'h7F);

    repeat (300) begin
      r = $urandom_range(0, 15);
      if (r < 2)       press(4'd14, $urandom_range(1, 3), $urandom_range(1, 6));
      else if (r == 2) press(4'd12, $urandom_range(1, 3), $urandom_range(1, 6));
      else             press(4'($urandom_range(0, 15)), $urandom_range(1, 3), $urandom_range(1, 6));
      if ($urandom_range(0, 19) == 0) cyc($urandom_range(0, (TO + 1) * SD));
    end

    cyc(10);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
